alu_muldiv: RTL and testbench

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_muldiv_if.sv | 32 +++
 rtl/alu_muldiv.sv | 178 +++++++++++++++++
 tb/tb_alu_muldiv.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if -- request/response bundle for the iterative MIPS HI/LO unit.
//   start  : operation request, sampled on the rising clock edge
//   func   : MIPS R-type funct code (mult/multu/div/divu/mthi/mtlo/mfhi/mflo)
//   a, b   : operands rs / rt
//   busy   : an iterative multiply/divide is in progress
//   done   : one-cycle pulse after HI/LO take an iterative result
//   hi, lo : HI and LO registers
//   result : hi when func is mfhi, otherwise lo
// master drives the request side, slave is the arithmetic unit.
interface alu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       func;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] result;

  modport master (
    output start, func, a, b,
    input  busy, done, hi, lo, result
  );

  modport slave (
    input  start, func, a, b,
    output busy, done, hi, lo, result
  );
endinterface

// File: rtl/alu_muldiv.sv
// alu_muldiv -- iterative multiply/divide unit with MIPS-style HI/LO registers.
// Multiplies by shift-add and divides by restoring shift-subtract, one bit per
// clock, on operand magnitudes; signs are reapplied in a final FIX cycle.
// Ports:
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-high reset (clears state, HI and LO)
//   bus : alu_muldiv_if.slave -- start/func/a/b in, busy/done/hi/lo/result out
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  alu_muldiv_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MFHI  = 6'b010000;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  // Two's complement negate when n is set.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  // Magnitude of v; the most negative value maps onto itself, which is the
  // correct unsigned magnitude 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return neg_w(v, sgn & v[WIDTH-1]);
  endfunction

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  // Operation context latched at start; datapath only, not reset.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   a_raw;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               b_zero;

  logic               op_signed;
  logic               sign_a;
  logic               sign_b;
  logic               is_muldiv;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  always_comb begin
    op_signed = (bus.func == F_MULT) || (bus.func == F_DIV);
    sign_a    = op_signed & bus.a[WIDTH-1];
    sign_b    = op_signed & bus.b[WIDTH-1];
    is_muldiv = (bus.func == F_MULT) || (bus.func == F_MULTU) ||
                (bus.func == F_DIV)  || (bus.func == F_DIVU);
  end

  // One iteration step. Multiply: acc = {partial, multiplier}, add the
  // multiplicand to the upper half when the multiplier LSB is set, then shift
  // right. Divide: acc = {remainder, dividend}, shift left one bit and keep the
  // trial subtraction when it does not borrow; quotient bits enter at the LSB.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff = div_sh - {1'b0, opnd};
    acc_next = {mul_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (!div_diff[WIDTH])
        acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_next = {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  // Sign correction. Divide by zero bypasses the iterative result: the
  // restoring loop already yields all-ones/dividend on magnitudes, but signed
  // correction would disturb that, so it is forced here.
  always_comb begin
    prod_fix = neg_2w(acc, neg_q);
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (b_zero) begin
        fix_hi = a_raw;
        fix_lo = {WIDTH{1'b1}};
      end else begin
        fix_hi = neg_w(acc[2*WIDTH-1:WIDTH], neg_r);
        fix_lo = neg_w(acc[WIDTH-1:0], neg_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (is_muldiv) begin
              is_div <= (bus.func == F_DIV) || (bus.func == F_DIVU);
              neg_q  <= sign_a ^ sign_b;
              neg_r  <= sign_a;
              b_zero <= (bus.b == '0);
              a_raw  <= bus.a;
              if ((bus.func == F_DIV) || (bus.func == F_DIVU)) begin
                acc  <= {{WIDTH{1'b0}}, mag(bus.a, op_signed)};
                opnd <= mag(bus.b, op_signed);
              end else begin
                acc  <= {{WIDTH{1'b0}}, mag(bus.b, op_signed)};
                opnd <= mag(bus.a, op_signed);
              end
              cnt   <= CW'(WIDTH);
              state <= CALC;
            end else if (bus.func == F_MTHI) begin
              hi_r <= bus.a;
            end else if (bus.func == F_MTLO) begin
              lo_r <= bus.a;
            end
          end
        end
        // ---- CALC: WIDTH iteration steps, then one terminal-count cycle ----
        CALC: begin
          busy_r <= 1'b1;
          if (cnt == '0) begin
            state <= FIX;
          end else begin
            acc <= acc_next;
            cnt <= cnt - 1'b1;
          end
        end
        // ---- FIX: sign-corrected result lands in HI/LO ----
        FIX: begin
          hi_r   <= fix_hi;
          lo_r   <= fix_lo;
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.hi     = hi_r;
  assign bus.lo     = lo_r;
  assign bus.result = (bus.func == F_MFHI) ? hi_r : lo_r;

endmodule

// File: tb/tb_alu_muldiv.sv
module tb_alu_muldiv;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  alu_muldiv_if #(.WIDTH(32)) bus ();
  alu_muldiv #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Reference: MIPS HI/LO semantics computed with plain integer arithmetic.
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv);
    longint sa, sb, p;
    int     ia, ib, q, r;
    logic [63:0] u;
    model = '0;
    case (f)
      F_MULT: begin
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        p  = sa * sb;
        model = p;
      end
      F_MULTU: begin
        u = {32'd0, av} * {32'd0, bv};
        model = u;
      end
      F_DIV: begin
        if (bv == 32'd0) model = {av, 32'hFFFFFFFF};
        else if (av == 32'h80000000 && bv == 32'hFFFFFFFF) model = {32'd0, 32'h80000000};
        else begin
          ia = av; ib = bv;
          q = ia / ib; r = ia % ib;
          model = {r, q};
        end
      end
      F_DIVU: begin
        if (bv == 32'd0) model = {av, 32'hFFFFFFFF};
        else model = {av % bv, av / bv};
      end
      default: model = '0;
    endcase
  endfunction

  // Issues one iterative op and follows it to done. lat counts edges from the
  // start edge to the edge at which done is first seen; bcnt counts observed
  // busy cycles; held reports that HI/LO never moved while waiting.
  task automatic run_op(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv,
                        input bit noise, output logic [31:0] ohi, output logic [31:0] olo,
                        output int lat, output int bcnt, output bit held);
    logic [31:0] h0, l0;
    @(negedge clk);
    h0 = bus.hi; l0 = bus.lo;
    bus.start = 1'b1; bus.func = f; bus.a = av; bus.b = bv;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0; bcnt = 0; held = 1'b1;
    while (lat < 200) begin
      if (noise) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.func  = 6'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
      end
      @(negedge clk);
      lat++;
      if (bus.busy) bcnt++;
      if (bus.done) break;
      if (bus.hi !== h0 || bus.lo !== l0) held = 1'b0;
    end
    bus.start = 1'b0;
    ohi = bus.hi; olo = bus.lo;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1; bus.func = F_MULT; bus.a = 32'h5; bus.b = 32'h7;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", bus.done); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h want=0", bus.hi); end
    checks++; if (bus.lo !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h want=0", bus.lo); end
    bus.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] h, l;
    int lat, bcnt;
    bit held;
    logic [5:0]  fv [5] = '{F_MULTU, F_MULT, F_DIV, F_DIVU, F_DIV};
    logic [31:0] av [5] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'h00000064, 32'h80000000};
    logic [31:0] bv [5] = '{32'hFFFFFFFF, 32'h00000007, 32'h00000002, 32'h00000000, 32'hFFFFFFFF};
    logic [31:0] eh [5] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000064, 32'h00000000};
    logic [31:0] el [5] = '{32'h00000001, 32'hFFFFFFEB, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000};
    for (int i = 0; i < 5; i++) begin
      run_op(fv[i], av[i], bv[i], 1'b0, h, l, lat, bcnt, held);
      checks++; if (h !== eh[i]) begin errors++; $display("FAIL directed%0d_hi got=%h want=%h", i, h, eh[i]); end
      checks++; if (l !== el[i]) begin errors++; $display("FAIL directed%0d_lo got=%h want=%h", i, l, el[i]); end
      checks++; if (lat !== 34) begin errors++; $display("FAIL directed%0d_latency got=%0d want=34", i, lat); end
      checks++; if (bcnt !== 33) begin errors++; $display("FAIL directed%0d_busy_cycles got=%0d want=33", i, bcnt); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL directed%0d_busy_at_done got=%b want=0", i, bus.busy); end
      @(negedge clk);
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL directed%0d_done_width got=%b want=0", i, bus.done); end
    end
  endtask

  task automatic test_random();
    logic [31:0] h, l, av, bv;
    logic [63:0] exp;
    logic [5:0]  f;
    logic [5:0]  ops [4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
    int lat, bcnt;
    bit held;
    for (int i = 0; i < 24; i++) begin
      f  = ops[$urandom_range(0, 3)];
      av = $urandom;
      bv = $urandom;
      case (i % 6)
        1: bv = 32'd0;
        2: bv = 32'($urandom_range(1, 15));
        3: begin av = 32'h80000000; bv = 32'hFFFFFFFF; end
        4: bv = -32'($urandom_range(1, 300));
        default: ;
      endcase
      exp = model(f, av, bv);
      run_op(f, av, bv, 1'b1, h, l, lat, bcnt, held);
      checks++; if (h !== exp[63:32] || l !== exp[31:0])
        begin errors++; $display("FAIL random%0d f=%b a=%h b=%h got=%h_%h want=%h_%h", i, f, av, bv, h, l, exp[63:32], exp[31:0]); end
      checks++; if (lat !== 34) begin errors++; $display("FAIL random%0d_latency got=%0d want=34", i, lat); end
      checks++; if (!held) begin errors++; $display("FAIL random%0d_hilo_held got=changed want=held", i); end
      bus.func = F_MFHI; #1;
      checks++; if (bus.result !== exp[63:32]) begin errors++; $display("FAIL random%0d_mfhi got=%h want=%h", i, bus.result, exp[63:32]); end
      bus.func = F_MFLO; #1;
      checks++; if (bus.result !== exp[31:0]) begin errors++; $display("FAIL random%0d_mflo got=%h want=%h", i, bus.result, exp[31:0]); end
    end
  endtask

  task automatic test_move();
    @(negedge clk);
    bus.start = 1'b1; bus.func = F_MTLO; bus.a = 32'hCAFEBABE;
    @(negedge clk);
    bus.start = 1'b1; bus.func = F_MTHI; bus.a = 32'h12345678;
    @(negedge clk);
    bus.start = 1'b0; bus.func = F_MFLO; bus.a = 32'h0;
    checks++; if (bus.hi !== 32'h12345678) begin errors++; $display("FAIL mthi got=%h want=12345678", bus.hi); end
    checks++; if (bus.lo !== 32'hCAFEBABE) begin errors++; $display("FAIL mtlo got=%h want=cafebabe", bus.lo); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL move_busy_done got=%b%b want=00", bus.busy, bus.done); end
    #1;
    checks++; if (bus.result !== 32'hCAFEBABE) begin errors++; $display("FAIL result_mflo got=%h want=cafebabe", bus.result); end
    bus.func = F_MFHI; #1;
    checks++; if (bus.result !== 32'h12345678) begin errors++; $display("FAIL result_mfhi got=%h want=12345678", bus.result); end
    bus.start = 1'b1; bus.func = F_MFHI; bus.a = 32'hDEADBEEF;
    @(negedge clk);
    bus.start = 1'b1; bus.func = 6'b111111;
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.hi !== 32'h12345678 || bus.lo !== 32'hCAFEBABE || bus.busy !== 1'b0)
      begin errors++; $display("FAIL other_func got=%h_%h busy=%b want=12345678_cafebabe busy=0", bus.hi, bus.lo, bus.busy); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] h, l;
    logic [63:0] exp;
    int lat, bcnt, dones;
    bit held;
    @(negedge clk);
    bus.start = 1'b1; bus.func = F_MULTU; bus.a = 32'h0000FFFF; bus.b = 32'h00010001;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got=%b want=1", bus.busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b want=0", bus.busy); end
    checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin errors++; $display("FAIL abort_hilo got=%h_%h want=0_0", bus.hi, bus.lo); end
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL abort_done got=%0d pulses want=0", dones); end
    checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin errors++; $display("FAIL abort_no_write got=%h_%h want=0_0", bus.hi, bus.lo); end
    exp = model(F_DIV, 32'hFFFF0001, 32'h00000123);
    run_op(F_DIV, 32'hFFFF0001, 32'h00000123, 1'b0, h, l, lat, bcnt, held);
    checks++; if (h !== exp[63:32] || l !== exp[31:0]) begin errors++; $display("FAIL after_abort got=%h_%h want=%h_%h", h, l, exp[63:32], exp[31:0]); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL after_abort_latency got=%0d want=34", lat); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] e1, e2;
    int lat;
    bit held;
    e1 = model(F_MULT, 32'h7FFF1234, 32'hF0000003);
    e2 = model(F_DIVU, 32'hDEADBEEF, 32'h00001001);
    @(negedge clk);
    bus.start = 1'b1; bus.func = F_MULT; bus.a = 32'h7FFF1234; bus.b = 32'hF0000003;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (lat < 200 && !bus.done) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_first_latency got=%0d want=34", lat); end
    checks++; if (bus.hi !== e1[63:32] || bus.lo !== e1[31:0]) begin errors++; $display("FAIL b2b_first got=%h_%h want=%h_%h", bus.hi, bus.lo, e1[63:32], e1[31:0]); end
    bus.start = 1'b1; bus.func = F_DIVU; bus.a = 32'hDEADBEEF; bus.b = 32'h00001001;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0; held = 1'b1;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (bus.done) break;
      if (bus.hi !== e1[63:32] || bus.lo !== e1[31:0]) held = 1'b0;
    end
    checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_second_latency got=%0d want=34", lat); end
    checks++; if (!held) begin errors++; $display("FAIL b2b_hold got=changed want=first result held"); end
    checks++; if (bus.hi !== e2[63:32] || bus.lo !== e2[31:0]) begin errors++; $display("FAIL b2b_second got=%h_%h want=%h_%h", bus.hi, bus.lo, e2[63:32], e2[31:0]); end
  endtask

  initial begin
    bus.start = 1'b0; bus.func = 6'd0; bus.a = '0; bus.b = '0;
    test_reset();
    test_directed();
    test_move();
    test_random();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
